// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and small helpers.
package md_unit_pkg;

  localparam int unsigned MD_OP_W = 2;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 2'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 2'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 2'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 2'd3;

  // Divides occupy the upper half of the op space.
  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter with a terminal-count flag; models fixed operation latency.
module md_latency_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc_c
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; result commits when the
// latency counter expires, and mthi/mtlo writes are accepted only while idle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         md_op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               we_hi,
  input  logic               we_lo,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               busy_d, done_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_tc_c;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   b_safe, q_s, r_s, q_u, r_u;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   res_hi, res_lo;

  md_latency_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .en       (state_q == S_RUN),
    .load_val (cnt_val),
    .count    (cnt),
    .tc_c     (cnt_tc_c)
  );

  // Result arithmetic on the latched operands; divisor forced to 1 on the special cases
  always_comb begin
    prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_zero = (b_q == '0);
    div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    b_safe   = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
    q_s      = $signed(a_q) / $signed(b_safe);
    r_s      = $signed(a_q) % $signed(b_safe);
    q_u      = a_q / b_safe;
    r_u      = a_q % b_safe;
    res_hi   = '0;
    res_lo   = '0;
    case (op_q)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (div_zero) begin
          res_lo = '1;
          res_hi = a_q;
        end else if (div_ovf) begin
          res_lo = a_q;
          res_hi = '0;
        end else begin
          res_lo = q_s;
          res_hi = r_s;
        end
      end
      default: begin
        if (div_zero) begin
          res_lo = '1;
          res_hi = a_q;
        end else begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    busy_d   = busy;
    done_d   = 1'b0;
    hi_d     = hi;
    lo_d     = lo;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          op_d     = md_op;
          a_d      = A;
          b_d      = B;
          cnt_load = 1'b1;
          cnt_val  = md_is_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end else begin
          if (we_hi) hi_d = wdata;
          if (we_lo) lo_d = wdata;
        end
      end
      default: begin
        if (cnt_tc_c) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      hi      <= hi_d;
      lo      <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic reference model.
module tb_md_unit;

  localparam int unsigned W    = 32;
  localparam int unsigned MULN = 5;
  localparam int unsigned DIVN = 10;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   md_op;
  logic [W-1:0] A, B, wdata;
  logic         we_hi, we_lo;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .A       (A),
    .B       (B),
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 1'b0;
    we_hi = 1'b0;
    we_lo = 1'b0;
  endtask

  // Reference: plain 64-bit / int arithmetic plus the architectural special cases
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = int'(a);
    sb = int'(b);
    eh = '0;
    el = '0;
    case (op)
      2'd0: begin
        sp = longint'(sa) * longint'(sb);
        eh = sp[63:32];
        el = sp[31:0];
      end
      2'd1: begin
        up = {32'h0, a} * {32'h0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      2'd2: begin
        if (b == 32'h0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = a;
          eh = 32'h0;
        end else begin
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 32'h0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_val;
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    int unsigned n;
    logic [31:0] eh, el;
    n = op[1] ? DIVN : MULN;
    model(op, a, b, eh, el);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    if (noise) begin
      we_hi = 1'b1;
      we_lo = 1'b1;
      wdata = $urandom;
    end
    tick;
    for (int unsigned k = 0; k < n; k++) begin
      check("busy_high", busy, 1);
      check("done_low", done, 0);
      check("hi_hold", hi, m_hi);
      check("lo_hold", lo, m_lo);
      idle_inputs;
      A     = $urandom;
      B     = $urandom;
      md_op = 2'($urandom);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        we_hi = 1'($urandom_range(0, 1));
        we_lo = 1'($urandom_range(0, 1));
        wdata = $urandom;
      end
      tick;
    end
    idle_inputs;
    m_hi = eh;
    m_lo = el;
    check("busy_fall", busy, 0);
    check("done_pulse", done, 1);
    check("hi_result", hi, m_hi);
    check("lo_result", lo, m_lo);
    tick;
    check("done_clear", done, 0);
  endtask

  task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
    we_hi = wh;
    we_lo = wl;
    wdata = d;
    tick;
    idle_inputs;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    check("mt_busy", busy, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs;
    md_op = 2'd0;
    A     = '0;
    B     = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset_n = 1'b1;
    tick;

    // Directed cases
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    run_op(2'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("multu_hi_const", hi, 32'h0000_0002);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    run_op(2'd3, 32'd7, 32'd0, 1'b0);
    check("divu0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu0_hi_const", hi, 32'd7);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("ovf_lo_const", lo, 32'h8000_0000);
    check("ovf_hi_const", hi, 32'h0);
    run_op(2'd2, 32'h8000_0000, 32'h0, 1'b0);
    mt(1'b1, 1'b0, 32'h0000_1234);
    check("mthi_const", hi, 32'h0000_1234);
    mt(1'b0, 1'b1, 32'hCAFE_F00D);
    mt(1'b1, 1'b1, 32'h5A5A_A5A5);
    // Writes and restarts during busy, and a write alongside start, are all dropped
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op(2'd2, 32'd100, 32'hFFFF_FFF9, 1'b1);

    // Reset mid-divide: immediate clear and no done pulse
    mt(1'b1, 1'b1, 32'hDEAD_BEEF);
    start = 1'b1;
    md_op = 2'd2;
    A     = 32'd1000;
    B     = 32'd3;
    tick;
    idle_inputs;
    repeat (3) tick;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    m_hi = '0;
    m_lo = '0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      check("arst_no_done", done, 0);
      check("arst_idle", busy, 0);
    end
    check("arst_hi_kept", hi, m_hi);

    // Randomized operations with interleaved mthi/mtlo
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO result registers. It is the sequential successor of the combinational ALU.
- Sits in the EX stage beside the ALU and serves mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Models fixed multi-cycle latency. The pipeline stalls on start|busy.

Parameters:
- WIDTH, 32, operand width and width of HI and LO.
- MUL_CYCLES, 5, cycles busy is held for a multiply (>=1).
- DIV_CYCLES, 10, cycles busy is held for a divide (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  launch the operation in md_op; sampled at the rising edge.
- md_op  input  2  mult=0, multu=1, div=2, divu=3.
- A  input  WIDTH  multiplicand or dividend.
- B  input  WIDTH  multiplier or divisor.
- we_hi  input  1  mthi write enable.
- we_lo  input  1  mtlo write enable.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse on the cycle after HI/LO commit.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: reset_n low clears, asynchronously, hi=0, lo=0, busy=0, done=0, counter=0, state=IDLE. Asserting reset mid-operation aborts it; no result is committed.
- States: IDLE and RUN.
  - IDLE -> RUN on start. Operands and op are latched at that edge.
  - RUN counts down N = MUL_CYCLES or DIV_CYCLES.
  - RUN -> IDLE at the edge where the counter expires. The result commits at that same edge.
- Timing: start sampled at edge T. busy=1 after edge T through edge T+N, i.e. exactly N cycles high. HI/LO update at edge T+N, where busy falls. done=1 for the cycle after edge T+N.
- hi/lo outputs are the registers directly. mfhi/mflo read them combinationally; the old value is visible while busy.
- start while busy is ignored; the upstream stall guarantees this never happens legally.
- we_hi/we_lo while busy are ignored.
- In IDLE, start with we_hi/we_lo in the same cycle: start wins and the write is dropped.
- we_hi and we_lo together: both registers are written with wdata.
- Results are computed on the latched operands:
  - mult: {hi,lo} = signed A * signed B, full 2*WIDTH product.
  - multu: same as mult, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (div/divu), committed after the full DIV_CYCLES: lo = all ones, hi = A.
- Signed overflow, div with A = most-negative and B = -1: lo = A, hi = 0.
- Combinational operators may be used on the latched operands. Only the commit timing is observable.
- Latched operands do not follow A/B changes after the start edge.

Decomposition:
- Op encodings md_mult/md_multu/md_div/md_divu go as defines in the shared constants.v, next to the ALU op codes.
- One sub-module is natural: md_latency_counter. It is a loadable down-counter with a terminal-count flag, parametrised by width and reused for MUL/DIV.
- Result arithmetic stays inline.

Test Plan:
- mult: A=0xFFFFFFFE (-2), B=3, start at edge T.
  - busy is high for exactly 5 cycles.
  - At edge T+5: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - done pulses one cycle.
- multu: same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div: A=-7, B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu: A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
- Signed overflow: div with A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake and reset:
  - we_hi with wdata=0x1234 in IDLE -> hi=0x1234 next edge.
  - we_lo during busy -> lo unchanged.
  - Second start during busy -> ignored; the first result commits on schedule.
  - reset_n pulsed low mid-div -> busy=0 and hi=lo=0 immediately; no done pulse.
